// File: rtl/usr_sequencer.sv
// usr_sequencer: drives an external 4-bit universal shift register (USR).
// An accepted request serially loads the latched data with four right
// shifts, then applies up to four shifts in the requested direction, and
// finally captures the USR value into result with a one-cycle done pulse.
module usr_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
    input  logic [2:0] shift_count,
    input  logic [3:0] load_data,
    input  logic       ser_in,
    input  logic [3:0] usr_out,
    output logic [1:0] usr_control,
    output logic       usr_in,
    output logic [3:0] usr_inn,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] result
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [1:0] CTL_HOLD  = 2'b00;
    localparam logic [1:0] CTL_RIGHT = 2'b01;
    localparam logic [1:0] CTL_LEFT  = 2'b10;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic [3:0] data_q, data_d;
    logic [3:0] result_q, result_d;
    logic       done_q, done_d;

    // State and datapath registers; reset also aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 3'd0;
            dir_q    <= 1'b0;
            data_q   <= 4'd0;
            result_q <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            data_q   <= data_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: the only block that looks at start.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        data_d   = data_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    data_d  = load_data;
                    // Anything beyond 4 shifts would only flush the register further.
                    cnt_d   = (shift_count > 3'd4) ? 3'd4 : shift_count;
                    idx_d   = 2'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = (cnt_q != 3'd0) ? SHIFT : CAPTURE;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                result_d = usr_out;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // USR controls decoded from registers only, so start never reaches the USR.
    always_comb begin
        usr_control = CTL_HOLD;
        usr_in      = 1'b0;
        ready       = 1'b0;
        case (state_q)
            IDLE: ready = 1'b1;
            LOAD: begin
                // Bit 0 enters first so that after four right shifts it sits at the LSB.
                usr_control = CTL_RIGHT;
                usr_in      = data_q[idx_q];
            end
            SHIFT: begin
                usr_control = dir_q ? CTL_LEFT : CTL_RIGHT;
                usr_in      = ser_in;
            end
            default: ;
        endcase
    end

    assign busy    = ~ready;
    assign usr_inn = 4'b0000;
    assign done    = done_q;
    assign result  = result_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed bench for usr_sequencer with a behavioural 4-bit USR attached.
module tb_usr_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] shift_count = 3'd0;
    logic [3:0] load_data = 4'd0;
    logic       ser_in = 1'b0;
    logic [3:0] usr_out;
    logic [1:0] usr_control;
    logic       usr_in;
    logic [3:0] usr_inn;
    logic       ready, busy, done;
    logic [3:0] result;

    int n_cmp = 0;
    int n_err = 0;
    int bad_ctl = 0;
    int done_cnt = 0;
    logic [1:0] ctl_log [0:31];
    logic       busy_e0;

    usr_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir),
        .shift_count(shift_count), .load_data(load_data), .ser_in(ser_in),
        .usr_out(usr_out), .usr_control(usr_control), .usr_in(usr_in),
        .usr_inn(usr_inn), .ready(ready), .busy(busy), .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    // Behavioural USR sharing the sequencer's reset.
    logic [3:0] usr_q;
    always @(posedge clk or posedge reset) begin
        if (reset) usr_q <= 4'd0;
        else case (usr_control)
            2'b01:   usr_q <= {usr_in, usr_q[3:1]};
            2'b10:   usr_q <= {usr_q[2:0], usr_in};
            default: usr_q <= usr_q;
        endcase
    end
    assign usr_out = usr_q;

    // Track illegal control codes and done pulses.
    always @(negedge clk) begin
        if (usr_control == 2'b11) bad_ctl++;
        if (done) done_cnt++;
    end

    // Issue one request and wait for done; ctl_log[k] is the control applied at edge Ek.
    // A nonzero glitch_at pulses start with different data before that edge.
    task automatic run_op(input logic [3:0] d, input logic dr, input logic [2:0] n,
                          input logic s, input int glitch_at, output int done_edge);
        load_data = d; dir = dr; shift_count = n; ser_in = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_e0 = busy;
        done_edge = -1;
        for (int k = 1; k < 24; k++) begin
            if (k == glitch_at) begin
                start = 1'b1; load_data = ~d; shift_count = 3'd0; dir = ~dr;
            end
            ctl_log[k] = usr_control;
            @(posedge clk); #1;
            if (k == glitch_at) begin
                start = 1'b0; load_data = d; shift_count = n; dir = dr;
            end
            if (done) begin
                done_edge = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
        n_cmp++; if (result !== 4'b0000) begin n_err++; $display("FAIL rst_result got=%b exp=0000", result); end
        n_cmp++; if (usr_control !== 2'b00) begin n_err++; $display("FAIL rst_ctl got=%b exp=00", usr_control); end
        n_cmp++; if (usr_in !== 1'b0) begin n_err++; $display("FAIL rst_usr_in got=%b exp=0", usr_in); end
        n_cmp++; if (usr_inn !== 4'b0000) begin n_err++; $display("FAIL rst_usr_inn got=%b exp=0000", usr_inn); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_only();
        int de;
        logic [1:0] exp_ctl [1:5];
        exp_ctl = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        run_op(4'b1011, 1'b0, 3'd0, 1'b0, 0, de);
        n_cmp++; if (busy_e0 !== 1'b1) begin n_err++; $display("FAIL load_busy_e0 got=%b exp=1", busy_e0); end
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (ctl_log[k] !== exp_ctl[k]) begin
                n_err++; $display("FAIL load_ctl[E%0d] got=%b exp=%b", k, ctl_log[k], exp_ctl[k]);
            end
        end
        n_cmp++; if (de !== 5) begin n_err++; $display("FAIL load_done_edge got=%0d exp=5", de); end
        n_cmp++; if (result !== 4'b1011) begin n_err++; $display("FAIL load_result got=%b exp=1011", result); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL load_ready_with_done got=%b exp=1", ready); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL load_done_one_cycle got=%b exp=0", done); end
        n_cmp++; if (result !== 4'b1011) begin n_err++; $display("FAIL load_result_hold got=%b exp=1011", result); end
    endtask

    task automatic test_shift_right();
        int de;
        run_op(4'b1011, 1'b0, 3'd2, 1'b0, 0, de);
        n_cmp++; if (ctl_log[5] !== 2'b01 || ctl_log[6] !== 2'b01 || ctl_log[7] !== 2'b00) begin
            n_err++; $display("FAIL right_ctl got=%b,%b,%b exp=01,01,00", ctl_log[5], ctl_log[6], ctl_log[7]);
        end
        n_cmp++; if (de !== 7) begin n_err++; $display("FAIL right_done_edge got=%0d exp=7", de); end
        n_cmp++; if (result !== 4'b0010) begin n_err++; $display("FAIL right_result got=%b exp=0010", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_shift_left();
        int de;
        run_op(4'b1011, 1'b1, 3'd1, 1'b1, 0, de);
        n_cmp++; if (ctl_log[5] !== 2'b10 || ctl_log[6] !== 2'b00) begin
            n_err++; $display("FAIL left_ctl got=%b,%b exp=10,00", ctl_log[5], ctl_log[6]);
        end
        n_cmp++; if (de !== 6) begin n_err++; $display("FAIL left_done_edge got=%0d exp=6", de); end
        n_cmp++; if (result !== 4'b0111) begin n_err++; $display("FAIL left_result got=%b exp=0111", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int dc, de;
        load_data = 4'b1011; dir = 1'b0; shift_count = 3'd3; ser_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (usr_control !== 2'b01) begin n_err++; $display("FAIL abort_in_shift got=%b exp=01", usr_control); end
        dc = done_cnt;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (usr_control !== 2'b00) begin n_err++; $display("FAIL abort_ctl got=%b exp=00", usr_control); end
        n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL abort_ready_busy got=%b%b exp=10", ready, busy); end
        n_cmp++; if (result !== 4'b0000) begin n_err++; $display("FAIL abort_result got=%b exp=0000", result); end
        n_cmp++; if (usr_in !== 1'b0) begin n_err++; $display("FAIL abort_usr_in got=%b exp=0", usr_in); end
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt !== dc) begin n_err++; $display("FAIL abort_no_done got=%0d exp=%0d", done_cnt, dc); end
        // Request issued straight after reset, with a stray start mid-operation.
        run_op(4'b0110, 1'b0, 3'd0, 1'b0, 2, de);
        n_cmp++; if (busy_e0 !== 1'b1) begin n_err++; $display("FAIL post_rst_accept got=%b exp=1", busy_e0); end
        n_cmp++; if (de !== 5) begin n_err++; $display("FAIL ignore_done_edge got=%0d exp=5", de); end
        n_cmp++; if (result !== 4'b0110) begin n_err++; $display("FAIL ignore_result got=%b exp=0110", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_clamp();
        int de;
        run_op(4'b1011, 1'b1, 3'd7, 1'b0, 0, de);
        n_cmp++; if (ctl_log[5] !== 2'b10 || ctl_log[8] !== 2'b10 || ctl_log[9] !== 2'b00) begin
            n_err++; $display("FAIL clamp_ctl got=%b,%b,%b exp=10,10,00", ctl_log[5], ctl_log[8], ctl_log[9]);
        end
        n_cmp++; if (de !== 9) begin n_err++; $display("FAIL clamp_done_edge got=%0d exp=9", de); end
        n_cmp++; if (result !== 4'b0000) begin n_err++; $display("FAIL clamp_result got=%b exp=0000", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int de = -1;
        load_data = 4'b1011; dir = 1'b0; shift_count = 3'd1; ser_in = 1'b1; start = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (done) begin de = k; break; end
        end
        n_cmp++; if (de !== 6) begin n_err++; $display("FAIL b2b_first_done_edge got=%0d exp=6", de); end
        n_cmp++; if (result !== 4'b1101) begin n_err++; $display("FAIL b2b_first_result got=%b exp=1101", result); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_with_done got=%b exp=1", ready); end
        load_data = 4'b0100; dir = 1'b1; shift_count = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        de = -1;
        for (int k = 1; k < 24; k++) begin
            @(posedge clk); #1;
            if (done) begin de = k; break; end
        end
        n_cmp++; if (de !== 7) begin n_err++; $display("FAIL b2b_second_done_edge got=%0d exp=7", de); end
        n_cmp++; if (result !== 4'b0011) begin n_err++; $display("FAIL b2b_second_result got=%b exp=0011", result); end
        n_cmp++; if (bad_ctl !== 0) begin n_err++; $display("FAIL ctl_11_seen got=%0d exp=0", bad_ctl); end
    endtask

    initial begin
        test_reset();
        test_load_only();
        test_shift_right();
        test_shift_left();
        test_reset_abort();
        test_clamp();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
